// File: rtl/comp_serial_param_if.sv
// Bit-serial comparator bus: operand bit pair with handshake in, running result and frame status out.
interface comp_serial_param_if;
  logic a;
  logic b;
  logic in_valid;
  logic start;
  logic gout;
  logic eout;
  logic lout;
  logic done;
  logic busy;

  modport master (
    output a, b, in_valid, start,
    input  gout, eout, lout, done, busy
  );

  modport slave (
    input  a, b, in_valid, start,
    output gout, eout, lout, done, busy
  );
endinterface

// File: rtl/comp_serial_param.sv
// Serial magnitude comparator over WIDTH-bit frames, MSB- or LSB-first.
// Optional macro COMP_SIGNED_EN treats operands as two's complement.
module comp_serial_param #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  comp_serial_param_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // One-hot encoding lines up directly with {gout,eout,lout}.
  typedef enum logic [2:0] {
    RES_GT = 3'b100,
    RES_EQ = 3'b010,
    RES_LT = 3'b001
  } res_t;

  res_t          r_res;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  logic          r_busy;

  logic [CW-1:0] w_idx;
  logic          w_last;
  logic          w_a_wins;
  res_t          w_base;
  res_t          w_next;

  always_comb begin
    w_idx    = bus.start ? '0 : r_cnt;
    w_last   = (w_idx == LAST);
    // Bit 0 of a frame starts from EQ; earlier frame's result holds until then.
    w_base   = (w_idx == '0) ? RES_EQ : r_res;
    w_a_wins = bus.a;
`ifdef COMP_SIGNED_EN
    if ((MSB_FIRST != 0) ? (w_idx == '0) : w_last)
      w_a_wins = ~bus.a;
`endif
    w_next = w_base;
    // MSB-first locks on the first difference; LSB-first lets later bits overwrite.
    if ((bus.a ^ bus.b) && ((MSB_FIRST == 0) || (w_base == RES_EQ)))
      w_next = w_a_wins ? RES_GT : RES_LT;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_res  <= RES_EQ;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else if (bus.in_valid) begin
      r_res  <= w_next;
      r_cnt  <= w_last ? '0 : w_idx + CW'(1);
      r_done <= w_last;
      r_busy <= ~w_last;
    end else if (bus.start) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_done <= 1'b0;
    end
  end

  assign {bus.gout, bus.eout, bus.lout} = r_res;
  assign bus.done = r_done;
  assign bus.busy = r_busy;

endmodule

// File: tb/tb_comp_serial_param.sv
// Directed bench for comp_serial_param: one MSB-first and one LSB-first instance, WIDTH=8.
module tb_comp_serial_param;

  logic clk = 1'b0;
  logic reset;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  comp_serial_param_if bus_m ();
  comp_serial_param_if bus_l ();

  comp_serial_param #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_m.slave)
  );

  comp_serial_param #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_l.slave)
  );

  function automatic logic [2:0] code(input byte c);
    case (c)
      "G":     return 3'b100;
      "L":     return 3'b001;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [2:0] res_m();
    return {bus_m.gout, bus_m.eout, bus_m.lout};
  endfunction

  function automatic logic [2:0] res_l();
    return {bus_l.gout, bus_l.eout, bus_l.lout};
  endfunction

  task automatic step_m(input logic av, input logic bv, input logic v, input logic s);
    bus_m.a = av; bus_m.b = bv; bus_m.in_valid = v; bus_m.start = s;
    @(posedge clk); #1;
  endtask

  task automatic step_l(input logic av, input logic bv, input logic v, input logic s);
    bus_l.a = av; bus_l.b = bv; bus_l.in_valid = v; bus_l.start = s;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus_l.a = 1'b1; bus_l.b = 1'b0; bus_l.in_valid = 1'b1; bus_l.start = 1'b1;
    step_m(1'b1, 1'b0, 1'b1, 1'b1);
    n_run++;
    if (res_m() !== 3'b010 || bus_m.busy !== 1'b0 || bus_m.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_m: gel=%b busy=%b done=%b, want gel=010 busy=0 done=0", res_m(), bus_m.busy, bus_m.done);
    end
    n_run++;
    if (res_l() !== 3'b010 || bus_l.busy !== 1'b0 || bus_l.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_l: gel=%b busy=%b done=%b, want gel=010 busy=0 done=0", res_l(), bus_l.busy, bus_l.done);
    end
    reset = 1'b1;
    bus_l.in_valid = 1'b0; bus_l.start = 1'b0;
    step_m(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_msb_unsigned();
    logic [7:0] av = 8'hA5;
    logic [7:0] bv = 8'hA3;
    string exp = "EEEEEGGG";
    for (int k = 0; k < 8; k++) begin
      step_m(av[7-k], bv[7-k], 1'b1, 1'b0);
      n_run++;
      if (res_m() !== code(exp[k]) || bus_m.busy !== (k < 7) || bus_m.done !== (k == 7)) begin
        n_fail++;
        $display("FAIL msb_a5_a3 bit%0d: gel=%b busy=%b done=%b, want gel=%b busy=%b done=%b",
                 k, res_m(), bus_m.busy, bus_m.done, code(exp[k]), (k < 7), (k == 7));
      end
    end
    step_m(1'b0, 1'b0, 1'b0, 1'b0);
    n_run++;
    if (res_m() !== 3'b100 || bus_m.busy !== 1'b0 || bus_m.done !== 1'b0) begin
      n_fail++;
      $display("FAIL after_done: gel=%b busy=%b done=%b, want gel=100 busy=0 done=0", res_m(), bus_m.busy, bus_m.done);
    end
  endtask

  task automatic test_lsb_unsigned();
    logic [7:0] av = 8'h01;
    logic [7:0] bv = 8'h80;
`ifdef COMP_SIGNED_EN
    string exp = "GGGGGGGG";
`else
    string exp = "GGGGGGGL";
`endif
    for (int k = 0; k < 8; k++) begin
      step_l(av[k], bv[k], 1'b1, 1'b0);
      n_run++;
      if (res_l() !== code(exp[k]) || bus_l.busy !== (k < 7) || bus_l.done !== (k == 7)) begin
        n_fail++;
        $display("FAIL lsb_01_80 bit%0d: gel=%b busy=%b done=%b, want gel=%b busy=%b done=%b",
                 k, res_l(), bus_l.busy, bus_l.done, code(exp[k]), (k < 7), (k == 7));
      end
    end
    step_l(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_sign_msb();
    logic [7:0] av = 8'h80;
    logic [7:0] bv = 8'h7F;
`ifdef COMP_SIGNED_EN
    string exp = "LLLLLLLL";
`else
    string exp = "GGGGGGGG";
`endif
    for (int k = 0; k < 8; k++) begin
      step_m(av[7-k], bv[7-k], 1'b1, 1'b0);
      n_run++;
      if (res_m() !== code(exp[k]) || bus_m.busy !== (k < 7) || bus_m.done !== (k == 7)) begin
        n_fail++;
        $display("FAIL msb_80_7f bit%0d: gel=%b busy=%b done=%b, want gel=%b busy=%b done=%b",
                 k, res_m(), bus_m.busy, bus_m.done, code(exp[k]), (k < 7), (k == 7));
      end
    end
  endtask

  task automatic test_gap();
    logic [7:0] v = 8'h3C;
    int dones = 0;
    for (int k = 0; k < 8; k++) begin
      step_m(v[7-k], v[7-k], 1'b1, 1'b0);
      dones += int'(bus_m.done);
      n_run++;
      if (res_m() !== 3'b010 || bus_m.busy !== (k < 7) || bus_m.done !== (k == 7)) begin
        n_fail++;
        $display("FAIL gap bit%0d: gel=%b busy=%b done=%b, want gel=010 busy=%b done=%b",
                 k, res_m(), bus_m.busy, bus_m.done, (k < 7), (k == 7));
      end
      if (k == 3) begin
        for (int g = 0; g < 3; g++) begin
          step_m(1'b1, 1'b0, 1'b0, 1'b0);
          dones += int'(bus_m.done);
          n_run++;
          if (res_m() !== 3'b010 || bus_m.busy !== 1'b1 || bus_m.done !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_idle%0d: gel=%b busy=%b done=%b, want gel=010 busy=1 done=0",
                     g, res_m(), bus_m.busy, bus_m.done);
          end
        end
      end
    end
    n_run++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL gap_done_count: got %0d, want 1", dones);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] av = 8'h10;
    logic [7:0] bv = 8'h20;
    string exp = "EELLLLLL";
    int dones = 0;
    for (int k = 0; k < 3; k++) begin
      step_m(1'b1, 1'b0, 1'b1, 1'b0);
      n_run++;
      if (res_m() !== 3'b100 || bus_m.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL pre_reset bit%0d: gel=%b busy=%b, want gel=100 busy=1", k, res_m(), bus_m.busy);
      end
    end
    reset = 1'b0;
    step_m(1'b1, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    n_run++;
    if (res_m() !== 3'b010 || bus_m.busy !== 1'b0 || bus_m.done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: gel=%b busy=%b done=%b, want gel=010 busy=0 done=0", res_m(), bus_m.busy, bus_m.done);
    end
    for (int k = 0; k < 8; k++) begin
      step_m(av[7-k], bv[7-k], 1'b1, 1'b0);
      dones += int'(bus_m.done);
      n_run++;
      if (res_m() !== code(exp[k]) || bus_m.busy !== (k < 7) || bus_m.done !== (k == 7)) begin
        n_fail++;
        $display("FAIL post_reset bit%0d: gel=%b busy=%b done=%b, want gel=%b busy=%b done=%b",
                 k, res_m(), bus_m.busy, bus_m.done, code(exp[k]), (k < 7), (k == 7));
      end
    end
    n_run++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL post_reset_done_count: got %0d, want 1", dones);
    end
  endtask

  task automatic test_start_restart();
    logic [7:0] a1 = 8'hF0;
    logic [7:0] b1 = 8'h0F;
    for (int k = 0; k < 5; k++)
      step_m(a1[7-k], b1[7-k], 1'b1, 1'b0);
    n_run++;
    if (res_m() !== 3'b100 || bus_m.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_start: gel=%b busy=%b, want gel=100 busy=1", res_m(), bus_m.busy);
    end
    // New frame 0x00 vs 0xFF; bit 0 rides on the start cycle.
    for (int k = 0; k < 8; k++) begin
      step_m(1'b0, 1'b1, 1'b1, (k == 0));
      n_run++;
      if (res_m() !== 3'b001 || bus_m.busy !== (k < 7) || bus_m.done !== (k == 7)) begin
        n_fail++;
        $display("FAIL restart bit%0d: gel=%b busy=%b done=%b, want gel=001 busy=%b done=%b",
                 k, res_m(), bus_m.busy, bus_m.done, (k < 7), (k == 7));
      end
    end
  endtask

  task automatic test_start_idle();
    logic [7:0] av = 8'h01;
    logic [7:0] bv = 8'h00;
    string exp = "EEEEEEEG";
    step_m(1'b1, 1'b0, 1'b0, 1'b1);
    n_run++;
    if (res_m() !== 3'b001 || bus_m.busy !== 1'b0 || bus_m.done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_idle_hold: gel=%b busy=%b done=%b, want gel=001 busy=0 done=0", res_m(), bus_m.busy, bus_m.done);
    end
    for (int k = 0; k < 3; k++)
      step_m(1'b1, 1'b1, 1'b1, 1'b0);
    step_m(1'b1, 1'b0, 1'b0, 1'b1);
    n_run++;
    if (res_m() !== 3'b010 || bus_m.busy !== 1'b0 || bus_m.done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_idle_mid: gel=%b busy=%b done=%b, want gel=010 busy=0 done=0", res_m(), bus_m.busy, bus_m.done);
    end
    for (int k = 0; k < 8; k++) begin
      step_m(av[7-k], bv[7-k], 1'b1, 1'b0);
      n_run++;
      if (res_m() !== code(exp[k]) || bus_m.busy !== (k < 7) || bus_m.done !== (k == 7)) begin
        n_fail++;
        $display("FAIL after_start bit%0d: gel=%b busy=%b done=%b, want gel=%b busy=%b done=%b",
                 k, res_m(), bus_m.busy, bus_m.done, code(exp[k]), (k < 7), (k == 7));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] av = 16'h3C_A5;
    logic [15:0] bv = 16'h3D_A3;
    string exp = "EEEEEEELEEEEEGGG";
    for (int k = 0; k < 16; k++) begin
      step_m(av[15-k], bv[15-k], 1'b1, 1'b0);
      n_run++;
      if (res_m() !== code(exp[k]) || bus_m.busy !== ((k % 8) < 7) || bus_m.done !== ((k % 8) == 7)) begin
        n_fail++;
        $display("FAIL b2b bit%0d: gel=%b busy=%b done=%b, want gel=%b busy=%b done=%b",
                 k, res_m(), bus_m.busy, bus_m.done, code(exp[k]), ((k % 8) < 7), ((k % 8) == 7));
      end
    end
    step_m(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    bus_m.a = 1'b0; bus_m.b = 1'b0; bus_m.in_valid = 1'b0; bus_m.start = 1'b0;
    bus_l.a = 1'b0; bus_l.b = 1'b0; bus_l.in_valid = 1'b0; bus_l.start = 1'b0;
    @(negedge clk);
    test_reset();
    test_msb_unsigned();
    test_lsb_unsigned();
    test_sign_msb();
    test_gap();
    test_reset_midframe();
    test_start_restart();
    test_start_idle();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
